// File: rtl/dmem_bridge.sv
// dmem_bridge: RV32 load/store port to a word-wide request/response bus; define DMEM_MISALIGN_SPLIT_EN to split misaligned accesses into two beats.
// Aligned load stalls 3 cycles, store 2; bus_req_valid is held until bus_req_ready and the CPU is stalled until DONE.
module dmem_bridge #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        CLK,
    input  logic        rst,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic [2:0]  cpu_type,
    input  logic        cpu_rd_en,
    input  logic        cpu_wr_en,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic        cpu_err,
    output logic        bus_req_valid,
    input  logic        bus_req_ready,
    output logic [31:0] bus_addr,
    output logic        bus_we,
    output logic [3:0]  bus_wstrb,
    output logic [31:0] bus_wdata,
    input  logic        bus_rsp_valid,
    input  logic [31:0] bus_rdata
);

`ifdef DMEM_MISALIGN_SPLIT_EN
    localparam logic SPLIT_EN = 1'b1;
`else
    localparam logic SPLIT_EN = 1'b0;
`endif

    localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ1,
        S_RSP1,
        S_REQ2,
        S_RSP2,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [31:0]   r_addr;
    logic [2:0]    r_type;
    logic [31:0]   r_wdata;
    logic          r_we;
    logic          r_split;
    logic          r_err;
    logic [31:0]   r_lo;
    logic [31:0]   r_hi;
    logic [TW-1:0] r_tcnt;

    logic        w_req;
    logic [1:0]  w_in_off;
    logic        w_in_unsup;
    logic        w_in_mis;
    logic        w_tmo;
    logic [1:0]  w_off;
    logic [7:0]  w_mask8;
    logic [7:0]  w_strb8;
    logic [63:0] w_wdat64;
    logic [63:0] w_rd64;
    logic [31:0] w_rword;
    logic [31:0] w_ext;
    logic        w_beat2;
    logic        w_req_st;

    assign w_req      = cpu_rd_en | cpu_wr_en;
    assign w_in_off   = cpu_addr[1:0];
    assign w_in_unsup = (cpu_type == 3'b011) || (cpu_type[2:1] == 2'b11);
    assign w_in_mis   = ((cpu_type[1:0] == 2'b01) && (w_in_off == 2'b11)) ||
                        ((cpu_type[1:0] == 2'b10) && (w_in_off != 2'b00));
    assign w_tmo      = (r_tcnt == TMO_LAST);

    // Lane placement over an 8-byte window: bytes that spill past the word go to beat 2.
    assign w_off = r_addr[1:0];
    always_comb begin
        w_mask8 = 8'h0F;
        case (r_type[1:0])
            2'b00:   w_mask8 = 8'h01;
            2'b01:   w_mask8 = 8'h03;
            default: w_mask8 = 8'h0F;
        endcase
    end
    assign w_strb8  = w_mask8 << w_off;
    assign w_wdat64 = {32'h0, r_wdata} << {w_off, 3'b000};

    assign w_rd64  = {r_hi, r_lo} >> {w_off, 3'b000};
    assign w_rword = w_rd64[31:0];
    always_comb begin
        w_ext = w_rword;
        case (r_type)
            3'b000:  w_ext = {{24{w_rword[7]}}, w_rword[7:0]};
            3'b001:  w_ext = {{16{w_rword[15]}}, w_rword[15:0]};
            3'b100:  w_ext = {24'h0, w_rword[7:0]};
            3'b101:  w_ext = {16'h0, w_rword[15:0]};
            default: w_ext = w_rword;
        endcase
    end

    assign w_beat2       = (r_state == S_REQ2);
    assign bus_req_valid = (r_state == S_REQ1) || (r_state == S_REQ2);
    assign w_req_st      = bus_req_valid & r_we;
    assign bus_addr      = bus_req_valid ? ({r_addr[31:2], 2'b00} + (w_beat2 ? 32'd4 : 32'd0)) : 32'h0;
    assign bus_we        = w_req_st;
    assign bus_wstrb     = w_req_st ? (w_beat2 ? w_strb8[7:4] : w_strb8[3:0]) : 4'h0;
    assign bus_wdata     = w_req_st ? (w_beat2 ? w_wdat64[63:32] : w_wdat64[31:0]) : 32'h0;

    assign cpu_rdata = ((r_state == S_DONE) && !r_we && !r_err) ? w_ext : 32'h0;
    assign cpu_err   = (r_state == S_DONE) && r_err;
    // Gated by rst so the freeze request drops the moment reset asserts.
    assign cpu_stall = rst && w_req && (r_state != S_DONE);

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    if (w_in_unsup || (w_in_mis && !SPLIT_EN)) begin
                        w_next = S_DONE;
                    end else begin
                        w_next = S_REQ1;
                    end
                end
            end
            S_REQ1: begin
                if (bus_req_ready) begin
                    if (r_we) begin
                        w_next = r_split ? S_REQ2 : S_DONE;
                    end else begin
                        w_next = S_RSP1;
                    end
                end
            end
            S_RSP1: begin
                if (bus_rsp_valid) begin
                    w_next = r_split ? S_REQ2 : S_DONE;
                end else if (w_tmo) begin
                    w_next = S_DONE;
                end
            end
            S_REQ2: begin
                if (bus_req_ready) begin
                    w_next = r_we ? S_DONE : S_RSP2;
                end
            end
            S_RSP2: begin
                if (bus_rsp_valid || w_tmo) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge rst) begin
        if (!rst) begin
            r_addr  <= 32'h0;
            r_type  <= 3'b000;
            r_wdata <= 32'h0;
            r_we    <= 1'b0;
            r_split <= 1'b0;
            r_err   <= 1'b0;
            r_lo    <= 32'h0;
            r_hi    <= 32'h0;
            r_tcnt  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_addr  <= cpu_addr;
                        r_type  <= cpu_type;
                        r_wdata <= cpu_wdata;
                        r_we    <= cpu_wr_en;
                        r_split <= w_in_mis && SPLIT_EN && !w_in_unsup;
                        r_err   <= w_in_unsup || (w_in_mis && !SPLIT_EN);
                        r_lo    <= 32'h0;
                        r_hi    <= 32'h0;
                        r_tcnt  <= '0;
                    end
                end
                S_REQ1, S_REQ2: begin
                    if (bus_req_ready) begin
                        r_tcnt <= '0;
                    end
                end
                S_RSP1: begin
                    if (bus_rsp_valid) begin
                        r_lo <= bus_rdata;
                    end else if (w_tmo) begin
                        r_err <= 1'b1;
                    end else begin
                        r_tcnt <= r_tcnt + TW'(1);
                    end
                end
                S_RSP2: begin
                    if (bus_rsp_valid) begin
                        r_hi <= bus_rdata;
                    end else if (w_tmo) begin
                        r_err <= 1'b1;
                    end else begin
                        r_tcnt <= r_tcnt + TW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_bridge.sv
// Bench for dmem_bridge: directed vector table, reset corner sequences, then random accesses vs a byte-lane reference model.
module tb_dmem_bridge;

    localparam int TMO = 4;
`ifdef DMEM_MISALIGN_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        rst;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, bus_addr, bus_wdata, bus_rdata;
    logic [2:0]  cpu_type;
    logic        cpu_rd_en, cpu_wr_en, cpu_stall, cpu_err;
    logic        bus_req_valid, bus_req_ready, bus_we, bus_rsp_valid;
    logic [3:0]  bus_wstrb;

    dmem_bridge #(.TIMEOUT_CYCLES(TMO)) dut (
        .CLK(CLK), .rst(rst),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_type(cpu_type),
        .cpu_rd_en(cpu_rd_en), .cpu_wr_en(cpu_wr_en),
        .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .cpu_err(cpu_err),
        .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
        .bus_addr(bus_addr), .bus_we(bus_we), .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata),
        .bus_rsp_valid(bus_rsp_valid), .bus_rdata(bus_rdata)
    );

    always #5 CLK = ~CLK;

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask

    // Observed results of one access
    int          got_stall, got_beats;
    logic        got_hang, got_err;
    logic [31:0] got_rdata;
    logic [31:0] got_addr[2];
    logic        got_we[2];
    logic [3:0]  got_strb[2];
    logic [31:0] got_wdata[2];

    // Reference expectations
    int          e_stall, e_beats;
    logic        e_err, e_we;
    logic [31:0] e_rdata;
    logic [31:0] e_addr[2];
    logic [3:0]  e_strb[2];
    logic [31:0] e_wdata[2];

    // Drives one CPU access and plays the bus: ready after rdy_lat waiting cycles,
    // response rsp_lat cycles after the transfer (0 = never).
    task automatic run_access(input logic [31:0] addr, input logic [2:0] typ, input logic rd, input logic wr,
                              input logic [31:0] wd, input logic [31:0] w0, input logic [31:0] w1,
                              input int rdy_lat, input int rsp_lat);
        int vwait, rsp_cnt, rbeat;
        bit pend, done;
        got_stall = 0; got_beats = 0; got_hang = 1'b0; got_err = 1'b0; got_rdata = '0;
        for (int b = 0; b < 2; b++) begin
            got_addr[b] = '0; got_we[b] = 1'b0; got_strb[b] = '0; got_wdata[b] = '0;
        end
        vwait = 0; rsp_cnt = 0; rbeat = 0; pend = 0; done = 0;
        for (int cyc = 0; cyc < 100 && !done; cyc++) begin
            @(negedge CLK);
            cpu_addr = addr; cpu_type = typ; cpu_rd_en = rd; cpu_wr_en = wr; cpu_wdata = wd;
            if (pend) rsp_cnt++;
            bus_req_ready = (vwait >= rdy_lat);
            bus_rsp_valid = pend && (rsp_lat != 0) && (rsp_cnt == rsp_lat);
            bus_rdata = bus_rsp_valid ? ((rbeat == 0) ? w0 : w1) : $urandom;
            #1;
            if (cpu_stall) got_stall++;
            if (bus_rsp_valid) begin pend = 0; rbeat++; end
            if (bus_req_valid) begin
                if (bus_req_ready) begin
                    if (got_beats < 2) begin
                        got_addr[got_beats] = bus_addr; got_we[got_beats] = bus_we;
                        got_strb[got_beats] = bus_wstrb; got_wdata[got_beats] = bus_wdata;
                    end
                    got_beats++;
                    if (!bus_we) begin pend = 1; rsp_cnt = 0; end
                    vwait = 0;
                end else begin
                    vwait++;
                end
            end
            if (!cpu_stall) begin
                got_rdata = cpu_rdata; got_err = cpu_err; done = 1;
            end
        end
        if (!done) got_hang = 1'b1;
    endtask

    task automatic idle_cycle();
        @(negedge CLK);
        cpu_rd_en = 1'b0; cpu_wr_en = 1'b0; bus_req_ready = 1'b0; bus_rsp_valid = 1'b0;
    endtask

    // Reference: walks the accessed bytes one by one over a two-word window.
    task automatic model(input logic [31:0] addr, input logic [2:0] typ, input logic wr,
                         input logic [31:0] wd, input logic [31:0] w0, input logic [31:0] w1,
                         input int rdy_lat, input int rsp_lat);
        int size, off, nb, p, bt, ln;
        bit unsup, mis, load;
        logic [31:0] words[2];
        logic [31:0] val;
        words[0] = w0; words[1] = w1;
        load  = !wr;
        unsup = (typ == 3) || (typ == 6) || (typ == 7);
        size  = (typ[1:0] == 2'd0) ? 1 : (typ[1:0] == 2'd1) ? 2 : 4;
        off   = int'(addr[1:0]);
        mis   = (off + size) > 4;
        e_we = !load; e_rdata = '0; e_err = 1'b0;
        e_addr[0] = addr & ~32'h3; e_addr[1] = (addr & ~32'h3) + 32'd4;
        for (int b = 0; b < 2; b++) begin e_strb[b] = '0; e_wdata[b] = '0; end
        if (unsup || (mis && !SPLIT)) begin
            e_beats = 0; e_err = 1'b1; e_stall = 1;
        end else if (load && rsp_lat == 0) begin
            e_beats = 1; e_err = 1'b1; e_stall = 1 + (1 + rdy_lat) + TMO;
        end else begin
            nb = mis ? 2 : 1;
            e_beats = nb;
            e_stall = 1 + nb * (1 + rdy_lat) + (load ? nb * rsp_lat : 0);
            val = '0;
            for (int i = 0; i < size; i++) begin
                p = off + i; bt = p / 4; ln = p % 4;
                if (!load) begin
                    e_strb[bt][ln] = 1'b1;
                    e_wdata[bt][8*ln +: 8] = wd[8*i +: 8];
                end else begin
                    val[8*i +: 8] = words[bt][8*ln +: 8];
                end
            end
            if (load) begin
                if (!typ[2] && size == 1 && val[7])  val = val | 32'hFFFFFF00;
                if (!typ[2] && size == 2 && val[15]) val = val | 32'hFFFF0000;
                e_rdata = val;
            end
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  typ;
        logic        rd;
        logic        wr;
        logic [31:0] wd;
        logic [31:0] w0;
        logic [31:0] w1;
        int          rl;
        int          sl;
        logic [31:0] x_rdata;
        logic        x_err;
        int          x_stall;
        int          x_beats;
        logic [31:0] x_addr0;
        logic [3:0]  x_strb0;
        logic [31:0] x_wdata0;
    } vec_t;

    vec_t tbl[14];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{32'h100, 3'b010, 1'b1, 1'b0, 32'h0, 32'hDEADBEEF, 32'h0, 0, 1, 32'hDEADBEEF, 1'b0, 3, 1, 32'h100, 4'h0, 32'h0};
        tbl[1]  = '{32'h203, 3'b000, 1'b0, 1'b1, 32'hA5, 32'h0, 32'h0, 0, 1, 32'h0, 1'b0, 2, 1, 32'h200, 4'h8, 32'hA5000000};
        tbl[2]  = '{32'h101, 3'b000, 1'b1, 1'b0, 32'h0, 32'h0000F000, 32'h0, 0, 1, 32'hFFFFFFF0, 1'b0, 3, 1, 32'h100, 4'h0, 32'h0};
        tbl[3]  = '{32'h101, 3'b100, 1'b1, 1'b0, 32'h0, 32'h0000F000, 32'h0, 0, 1, 32'h000000F0, 1'b0, 3, 1, 32'h100, 4'h0, 32'h0};
`ifdef DMEM_MISALIGN_SPLIT_EN
        tbl[4]  = '{32'h102, 3'b010, 1'b1, 1'b0, 32'h0, 32'h3344ABCD, 32'h99881122, 0, 1, 32'h11223344, 1'b0, 5, 2, 32'h100, 4'h0, 32'h0};
        tbl[13] = '{32'h103, 3'b001, 1'b0, 1'b1, 32'h0000ABCD, 32'h0, 32'h0, 0, 1, 32'h0, 1'b0, 3, 2, 32'h100, 4'h8, 32'hCD000000};
`else
        tbl[4]  = '{32'h102, 3'b010, 1'b1, 1'b0, 32'h0, 32'h3344ABCD, 32'h99881122, 0, 1, 32'h0, 1'b1, 1, 0, 32'h0, 4'h0, 32'h0};
        tbl[13] = '{32'h103, 3'b001, 1'b0, 1'b1, 32'h0000ABCD, 32'h0, 32'h0, 0, 1, 32'h0, 1'b1, 1, 0, 32'h0, 4'h0, 32'h0};
`endif
        tbl[5]  = '{32'h100, 3'b010, 1'b1, 1'b0, 32'h0, 32'h12345678, 32'h0, 0, 0, 32'h0, 1'b1, 6, 1, 32'h100, 4'h0, 32'h0};
        tbl[6]  = '{32'h100, 3'b011, 1'b1, 1'b0, 32'h0, 32'h12345678, 32'h0, 0, 1, 32'h0, 1'b1, 1, 0, 32'h0, 4'h0, 32'h0};
        tbl[7]  = '{32'h102, 3'b001, 1'b0, 1'b1, 32'h1234BEEF, 32'h0, 32'h0, 0, 1, 32'h0, 1'b0, 2, 1, 32'h100, 4'hC, 32'hBEEF0000};
        tbl[8]  = '{32'h102, 3'b001, 1'b1, 1'b0, 32'h0, 32'h80010000, 32'h0, 0, 1, 32'hFFFF8001, 1'b0, 3, 1, 32'h100, 4'h0, 32'h0};
        tbl[9]  = '{32'h102, 3'b101, 1'b1, 1'b0, 32'h0, 32'h80010000, 32'h0, 0, 1, 32'h00008001, 1'b0, 3, 1, 32'h100, 4'h0, 32'h0};
        tbl[10] = '{32'h300, 3'b010, 1'b1, 1'b1, 32'hCAFEF00D, 32'h55555555, 32'h0, 0, 1, 32'h0, 1'b0, 2, 1, 32'h300, 4'hF, 32'hCAFEF00D};
        tbl[11] = '{32'h304, 3'b010, 1'b0, 1'b1, 32'h12345678, 32'h0, 32'h0, 2, 1, 32'h0, 1'b0, 4, 1, 32'h304, 4'hF, 32'h12345678};
        tbl[12] = '{32'h103, 3'b000, 1'b1, 1'b0, 32'h0, 32'h7F000000, 32'h0, 0, 4, 32'h0000007F, 1'b0, 6, 1, 32'h100, 4'h0, 32'h0};

        // Reset state, with a request pending to show the stall is forced low
        rst = 1'b0;
        cpu_addr = 32'h100; cpu_wdata = '0; cpu_type = 3'b010; cpu_rd_en = 1'b1; cpu_wr_en = 1'b0;
        bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rdata = '0;
        repeat (2) @(negedge CLK);
        #1;
        chk("rst_stall", cpu_stall, 0);
        chk("rst_req_valid", bus_req_valid, 0);
        chk("rst_err", cpu_err, 0);
        chk("rst_rdata", cpu_rdata, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_bus_wstrb_we", {bus_wstrb, bus_we}, 0);
        @(negedge CLK);
        rst = 1'b1; cpu_rd_en = 1'b0;
        idle_cycle();

        foreach (tbl[k]) begin
            run_access(tbl[k].addr, tbl[k].typ, tbl[k].rd, tbl[k].wr, tbl[k].wd, tbl[k].w0, tbl[k].w1,
                       tbl[k].rl, tbl[k].sl);
            chk($sformatf("vec%0d_hang", k), got_hang, 0);
            chk($sformatf("vec%0d_stall", k), got_stall, tbl[k].x_stall);
            chk($sformatf("vec%0d_beats", k), got_beats, tbl[k].x_beats);
            chk($sformatf("vec%0d_rdata", k), got_rdata, tbl[k].x_rdata);
            chk($sformatf("vec%0d_err", k), got_err, tbl[k].x_err);
            if (tbl[k].x_beats > 0 && got_beats > 0) begin
                chk($sformatf("vec%0d_addr0", k), got_addr[0], tbl[k].x_addr0);
                chk($sformatf("vec%0d_strb0", k), got_strb[0], tbl[k].x_strb0);
                if (tbl[k].wr) chk($sformatf("vec%0d_wdata0", k), got_wdata[0], tbl[k].x_wdata0);
            end
            idle_cycle();
        end

        // Reset asserted while waiting in RSP1, then a stale response after release
        @(negedge CLK);
        cpu_addr = 32'h100; cpu_type = 3'b010; cpu_rd_en = 1'b1; cpu_wr_en = 1'b0; bus_req_ready = 1'b1;
        @(negedge CLK);
        #1 chk("mid_req_valid", bus_req_valid, 1);
        @(negedge CLK);
        bus_req_ready = 1'b0;
        #1 chk("mid_rsp_stall", cpu_stall, 1);
        rst = 1'b0;
        #1;
        chk("mid_rst_stall", cpu_stall, 0);
        chk("mid_rst_req_valid", bus_req_valid, 0);
        chk("mid_rst_err", cpu_err, 0);
        chk("mid_rst_bus_addr", bus_addr, 0);
        @(negedge CLK);
        cpu_rd_en = 1'b0; rst = 1'b1; bus_rsp_valid = 1'b1; bus_rdata = 32'hDEADBEEF;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            #1;
            chk($sformatf("late_rsp_req_valid%0d", i), bus_req_valid, 0);
            chk($sformatf("late_rsp_err%0d", i), cpu_err, 0);
            chk($sformatf("late_rsp_rdata%0d", i), cpu_rdata, 0);
        end
        idle_cycle();

        // Random accesses against the reference model
        for (int n = 0; n < 200; n++) begin
            logic [2:0]  typs[10];
            logic [31:0] a, wd, w0, w1;
            logic [2:0]  t;
            logic        rd, wr;
            int          m, rl, sl;
            typs = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd2, 3'd1, 3'd3, 3'd6, 3'd7};
            t  = typs[$urandom_range(0, 9)];
            a  = 32'h1000 + ($urandom & 32'hFFF);
            m  = $urandom_range(1, 3);
            rd = m[0]; wr = m[1];
            wd = $urandom; w0 = $urandom; w1 = $urandom;
            rl = $urandom_range(0, 2);
            sl = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 4);
            model(a, t, wr, wd, w0, w1, rl, sl);
            run_access(a, t, rd, wr, wd, w0, w1, rl, sl);
            chk($sformatf("rnd%0d_hang", n), got_hang, 0);
            chk($sformatf("rnd%0d_stall", n), got_stall, e_stall);
            chk($sformatf("rnd%0d_beats", n), got_beats, e_beats);
            chk($sformatf("rnd%0d_rdata", n), got_rdata, e_rdata);
            chk($sformatf("rnd%0d_err", n), got_err, e_err);
            for (int b = 0; b < 2; b++) begin
                if (b < e_beats && b < got_beats) begin
                    logic [31:0] msk;
                    for (int j = 0; j < 4; j++) msk[8*j +: 8] = {8{e_strb[b][j]}};
                    chk($sformatf("rnd%0d_addr%0d", n, b), got_addr[b], e_addr[b]);
                    chk($sformatf("rnd%0d_we%0d", n, b), got_we[b], e_we);
                    chk($sformatf("rnd%0d_strb%0d", n, b), got_strb[b], e_strb[b]);
                    if (e_we) chk($sformatf("rnd%0d_wdata%0d", n, b), got_wdata[b] & msk, e_wdata[b]);
                end
            end
            if ($urandom_range(0, 1) == 1) idle_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
